seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver: watches the scanned `segments`/`anodes` bus and rebuilds the displayed digits as packed BCD.
- Intended uses: on-chip loopback self-check of the wall-clock display path, and a bench monitor that reads back hours/minutes/seconds.
- Runs on the system clock and oversamples the slow display scan.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (anode width); 1..8.
- STABLE_CYCLES, 4, consecutive identical one-hot anode samples required before a digit is captured; >=1.
- TIMEOUT_CYCLES, 1000000, system clocks without a capture before the stall flag sets (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- segments  in  7  scanned segment lines, active-low; bit0=a .. bit6=g.
- anodes  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- err_clr  in  1  clears sticky error flags.
- digits  out  4*NUM_DIGITS  last complete frame; digit i in [4i+3:4i].
- blank_mask  out  NUM_DIGITS  bit i=1 if digit i was blank in last frame.
- frame_valid  out  1  one-cycle pulse when digits/blank_mask update.
- err_multi  out  1  sticky: more than one anode active in the same sample.
- err_code  out  1  sticky: unrecognised segment pattern captured.
- stalled  out  1  scan stopped (optional feature; tied 0 otherwise).

Behaviour:
- Input stage: `segments`/`anodes` registered once (a_q, s_q). All decisions use a_q/s_q, giving 1 cycle of input latency.
- Inverted a_q classifies each cycle:
  - NONE: zero anodes active. Stable counter cleared; capture-done flag cleared.
  - ONE: exactly one anode active. If it equals the previous sample, the counter increments and saturates at STABLE_CYCLES. Otherwise the counter loads 1 and capture-done clears.
  - MULTI: two or more anodes active. Sets err_multi; counter and capture-done cleared.
- Capture: in the cycle the counter reaches STABLE_CYCLES with capture-done=0, decode s_q into the shadow slot of the active digit, set that digit's seen bit, set capture-done. At most one capture per dwell.
- Decode (active-high g..a after inversion):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00 (all off) → 4'hF, blank bit set.
  - Any other pattern → 4'hE and err_code set.
- Re-capture of an already-seen digit before the frame completes overwrites its shadow slot. No error.
- Frame completion: the capture that makes seen all-ones loads shadow into digits/blank_mask on that same edge. frame_valid is high for exactly the following cycle, and seen clears on the same edge. Next frame starts immediately.
- Flag priority: err_clr clears err_multi/err_code. A new error in the same cycle wins (flag stays 1).
- Reset values: digits all 4'hF, blank_mask all 1, frame_valid 0, err_multi 0, err_code 0, stalled 0. Internal: a_q all 1, s_q 7'h7F, counter 0, seen 0, capture-done 0, shadow all F.
- Reset mid-frame discards the partial frame. Captures restart from an empty seen mask on the next dwell.
- NUM_DIGITS=1: every capture completes a frame.

Optional Feature:
- Macro SEG7_SCAN_TIMEOUT_EN.
- Defined: a counter clears on every capture and increments otherwise. On reaching TIMEOUT_CYCLES it sets stalled, clears seen and holds at the limit.
  - stalled clears on the next capture.
  - digits is not changed by a timeout.
- Undefined: no counter logic; stalled tied to 0; TIMEOUT_CYCLES unused.

Test Plan:
1. Reset, then scan 8 digits showing "12:34:56"-style BCD 0x00123456 with leading blanks: dwell 6 cycles per digit and 2 NONE cycles between digits. → After the digit-7 capture, frame_valid pulses once, digits=0xFF123456, blank_mask=0xC0, no errors.
2. Dwell of STABLE_CYCLES-1 (3 cycles) on digit 2 within an otherwise normal scan. → No capture for digit 2, no frame_valid until a later dwell of ≥4 cycles on digit 2.
3. anodes=8'b11111100 for 5 cycles. → err_multi=1 two cycles later, no capture. err_clr pulse → err_multi=0.
4. Digit 3 driven with segment pattern g..a=7'h49 (inverted on bus). → digits[15:12]=4'hE after the frame, err_code=1.
5. Assert reset with 5 of 8 digits captured, release, then scan a full frame of all 9s. → Exactly one frame_valid, digits=0x99999999, with no stale values from before reset.
6. (SEG7_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=50) Stop scanning (anodes all 1) for 60 cycles. → stalled=1, digits unchanged. Resume scanning → stalled=0 at the first capture; next frame_valid only after all 8 digits are recaptured.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment bus plus the decoded-frame view, shared by the display scanner and the decoder.
// Latency/backpressure: none here; this file only bundles signals (no flow control, the scan is free-running).
// Ports: segments/anodes/err_clr come from the scanner side; digits/blank_mask/frame_valid/err_multi/err_code/stalled come from the decoder side.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    err_clr;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    frame_valid;
  logic                    err_multi;
  logic                    err_code;
  logic                    stalled;

  // Scanner side: drives the display bus, observes the decoded result.
  modport master (
    output segments, anodes, err_clr,
    input  digits, blank_mask, frame_valid, err_multi, err_code, stalled
  );

  // Decoder side: watches the display bus, publishes the decoded result.
  modport slave (
    input  segments, anodes, err_clr,
    output digits, blank_mask, frame_valid, err_multi, err_code, stalled
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Rebuilds packed BCD digits from a multiplexed active-low 7-segment scan (loopback self-check / bench monitor).
// Latency: 1 input register stage; a digit is captured after STABLE_CYCLES identical one-hot samples, frame_valid the cycle after the last capture.
// Backpressure: none; pure observer of a free-running scan, results overwrite each frame.
// Ports: clk, reset (sync, active-high), bus (slave modport: segments, anodes, err_clr in; digits, blank_mask, frame_valid, err_multi, err_code, stalled out).
// Optional stall detector under macro SEG7_SCAN_TIMEOUT_EN (stalled tied 0 when undefined).
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Returns {bcd[3:0], blank, bad} for an active-high g..a pattern.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {4'h0, 2'b00};
      7'h06:   decode = {4'h1, 2'b00};
      7'h5B:   decode = {4'h2, 2'b00};
      7'h4F:   decode = {4'h3, 2'b00};
      7'h66:   decode = {4'h4, 2'b00};
      7'h6D:   decode = {4'h5, 2'b00};
      7'h7D:   decode = {4'h6, 2'b00};
      7'h07:   decode = {4'h7, 2'b00};
      7'h7F:   decode = {4'h8, 2'b00};
      7'h6F:   decode = {4'h9, 2'b00};
      7'h00:   decode = {4'hF, 2'b10};
      default: decode = {4'hE, 2'b01};
    endcase
  endfunction

  logic [NUM_DIGITS-1:0]   a_q, a_prev;
  logic [6:0]              s_q;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    done, done_nxt;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   shadow_blank, blank_nxt;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic                    frame_valid_r, err_multi_r, err_code_r;

  logic [NUM_DIGITS-1:0]   act;
  logic                    none, multi, one, capture, full, tmo_hit;
  logic [IW-1:0]           idx;
  logic [5:0]              dec;

  assign act   = ~a_q;
  assign none  = (act == '0);
  // Clearing the lowest set bit leaves something only if two or more anodes are on.
  assign multi = |(act & (act - NUM_DIGITS'(1)));
  assign one   = !none && !multi;
  assign dec   = decode(~s_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act[i]) idx = IW'(i);
    end
  end

  // Dwell tracking: the counter saturates so one long dwell yields one capture.
  always_comb begin
    cnt_nxt  = cnt;
    done_nxt = done;
    capture  = 1'b0;
    if (!one) begin
      cnt_nxt  = '0;
      done_nxt = 1'b0;
    end else if (a_q == a_prev) begin
      if (cnt != CW'(STABLE_CYCLES)) cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt  = CW'(1);
      done_nxt = 1'b0;
    end
    if (one && (cnt_nxt == CW'(STABLE_CYCLES)) && !done_nxt) begin
      capture  = 1'b1;
      done_nxt = 1'b1;
    end
  end

  always_comb begin
    shadow_nxt = shadow;
    blank_nxt  = shadow_blank;
    seen_nxt   = seen;
    if (capture) begin
      shadow_nxt[4*idx +: 4] = dec[5:2];
      blank_nxt[idx]         = dec[1];
      seen_nxt               = seen | act;
    end
  end

  assign full = capture && (seen_nxt == '1);

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          stalled_r;

  // Fires on the increment that reaches the limit; the counter then holds there.
  assign tmo_hit = !capture && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= '0;
      stalled_r <= 1'b0;
    end else if (capture) begin
      tmo_cnt   <= '0;
      stalled_r <= 1'b0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) stalled_r <= 1'b1;
    end
  end

  assign bus.stalled = stalled_r;
`else
  assign tmo_hit     = 1'b0;
  assign bus.stalled = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q           <= '1;
      a_prev        <= '1;
      s_q           <= 7'h7F;
      cnt           <= '0;
      done          <= 1'b0;
      seen          <= '0;
      shadow        <= '1;
      shadow_blank  <= '1;
      digits_r      <= '1;
      blank_r       <= '1;
      frame_valid_r <= 1'b0;
      err_multi_r   <= 1'b0;
      err_code_r    <= 1'b0;
    end else begin
      a_q          <= bus.anodes;
      s_q          <= bus.segments;
      a_prev       <= a_q;
      cnt          <= cnt_nxt;
      done         <= done_nxt;
      shadow       <= shadow_nxt;
      shadow_blank <= blank_nxt;
      // A completed frame or a scan stall both start a fresh frame.
      seen          <= (full || tmo_hit) ? '0 : seen_nxt;
      frame_valid_r <= full;
      if (full) begin
        digits_r <= shadow_nxt;
        blank_r  <= blank_nxt;
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      if (multi)              err_multi_r <= 1'b1;
      else if (bus.err_clr)   err_multi_r <= 1'b0;
      if (capture && dec[0])  err_code_r  <= 1'b1;
      else if (bus.err_clr)   err_code_r  <= 1'b0;
    end
  end

  assign bus.digits      = digits_r;
  assign bus.blank_mask  = blank_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.err_multi   = err_multi_r;
  assign bus.err_code    = err_code_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: frame vector table, hand-written corner sequences, randomized dwells vs. a dwell-level model.
// Latency: drives inputs 1 time unit after the rising edge and samples there or on the falling edge.
// Backpressure: not applicable; the scan is free-running.
module tb_seg7_scan_decoder;
  localparam int ND = 8;
  localparam int SC = 4;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int fv_count = 0;
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.frame_valid === 1'b1) begin
      fv_count++;
      obs_q.push_back({bus.digits, bus.blank_mask});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.anodes   = '1;
    bus.segments = 7'h7F;
    cyc(n);
  endtask

  task automatic dwell(input int d, input logic [6:0] pat, input int n);
    bus.anodes   = ~(ND'(1) << d);
    bus.segments = ~pat;
    cyc(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    fv_count = 0;
    obs_q.delete();
  endtask

  task automatic scan_digits(input logic [55:0] pats, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) begin
      dwell(d, pats[7*d +: 7], 6);
      idle(2);
    end
    idle(3);
  endtask

  function automatic logic [55:0] p8(input logic [6:0] p7, p6, p5, p4, p3, p2, p1, p0);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // {value, blank, bad} from the glyph list: search, not a case on patterns.
  function automatic logic [5:0] ref_dec(input logic [6:0] p);
    if (p == 7'h00) return {4'hF, 2'b10};
    for (int k = 0; k < 10; k++) begin
      if (glyph[k] == p) return {4'(k), 2'b00};
    end
    return {4'hE, 2'b01};
  endfunction

  typedef struct {
    logic [55:0] pats;
    logic [31:0] exp_d;
    logic [7:0]  exp_b;
    logic        exp_err;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{p8(7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D), 32'hFF123456, 8'hC0, 1'b0};
    vt[1] = '{p8(7'h07, 7'h7D, 7'h6D, 7'h66, 7'h49, 7'h5B, 7'h06, 7'h3F), 32'h7654E210, 8'h00, 1'b1};
    vt[2] = '{p8(7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F), 32'h99999999, 8'h00, 1'b0};
    vt[3] = '{p8(7'h7F, 7'h6F, 7'h3F, 7'h00, 7'h4F, 7'h00, 7'h07, 7'h7F), 32'h890F3F78, 8'h14, 1'b0};
    vt[4] = '{p8(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), 32'hFFFFFFFF, 8'hFF, 1'b0};
    vt[5] = '{p8(7'h66, 7'h66, 7'h66, 7'h66, 7'h66, 7'h66, 7'h66, 7'h7E), 32'h4444444E, 8'h00, 1'b1};

    reset       = 1'b1;
    bus.err_clr = 1'b0;
    do_reset();

    // Reset state
    chk("rst_digits", bus.digits, 32'hFFFFFFFF);
    chk("rst_blank", bus.blank_mask, 8'hFF);
    chk("rst_fv", bus.frame_valid, 1'b0);
    chk("rst_err_multi", bus.err_multi, 1'b0);
    chk("rst_err_code", bus.err_code, 1'b0);
    chk("rst_stalled", bus.stalled, 1'b0);

    // Frame table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      scan_digits(vt[v].pats, 0, ND - 1);
      chk($sformatf("vec%0d_fv_count", v), fv_count, 1);
      chk($sformatf("vec%0d_digits", v), bus.digits, vt[v].exp_d);
      chk($sformatf("vec%0d_blank", v), bus.blank_mask, vt[v].exp_b);
      chk($sformatf("vec%0d_err_code", v), bus.err_code, vt[v].exp_err);
      chk($sformatf("vec%0d_err_multi", v), bus.err_multi, 1'b0);
    end

    // Short dwell on digit 2 is ignored until a long enough one arrives
    do_reset();
    for (int d = 0; d < ND; d++) begin
      dwell(d, vt[0].pats[7*d +: 7], (d == 2) ? SC - 1 : 6);
      idle(2);
    end
    idle(3);
    chk("short_dwell_no_frame", fv_count, 0);
    dwell(2, vt[0].pats[14 +: 7], SC);
    idle(4);
    chk("short_dwell_frame", fv_count, 1);
    chk("short_dwell_digits", bus.digits, 32'hFF123456);

    // Two anodes at once
    do_reset();
    bus.anodes   = 8'b11111100;
    bus.segments = ~7'h06;
    cyc(1);
    chk("multi_not_yet", bus.err_multi, 1'b0);
    cyc(1);
    chk("multi_set", bus.err_multi, 1'b1);
    cyc(3);
    idle(3);
    chk("multi_no_frame", fv_count, 0);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("multi_cleared", bus.err_multi, 1'b0);
    bus.anodes = 8'b11110101;
    cyc(1);
    bus.anodes   = '1;
    bus.err_clr  = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("multi_beats_clr", bus.err_multi, 1'b1);
    idle(2);
    scan_digits(vt[2].pats, 1, ND - 1);
    chk("multi_no_capture", fv_count, 0);

    // Reset mid-frame discards partial captures
    do_reset();
    scan_digits(vt[5].pats, 0, 4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    fv_count = 0;
    chk("midrst_digits", bus.digits, 32'hFFFFFFFF);
    scan_digits(vt[2].pats, 5, ND - 1);
    chk("midrst_no_stale_frame", fv_count, 0);
    scan_digits(vt[2].pats, 0, ND - 1);
    chk("midrst_one_frame", fv_count, 1);
    chk("midrst_digits_9", bus.digits, 32'h99999999);

`ifdef SEG7_SCAN_TIMEOUT_EN
    do_reset();
    scan_digits(vt[0].pats, 0, ND - 1);
    scan_digits(vt[2].pats, 0, 3);
    idle(60);
    chk("tmo_stalled", bus.stalled, 1'b1);
    chk("tmo_digits_kept", bus.digits, 32'hFF123456);
    dwell(4, vt[2].pats[28 +: 7], 6);
    idle(1);
    chk("tmo_resumed", bus.stalled, 1'b0);
    scan_digits(vt[2].pats, 5, ND - 1);
    chk("tmo_partial_discarded", fv_count, 1);
    scan_digits(vt[2].pats, 0, 3);
    chk("tmo_new_frame", fv_count, 2);
    chk("tmo_new_digits", bus.digits, 32'h99999999);
`endif

    // Randomized dwells against a dwell-level model
    begin
      logic [3:0] m_val [ND];
      logic [ND-1:0] m_blank, m_seen;
      logic m_err_c, m_err_m;
      logic [31:0] pk;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < ND; i++) m_val[i] = 4'hF;
      m_blank = '1;
      m_seen  = '0;
      m_err_c = 1'b0;
      m_err_m = 1'b0;
      for (int k = 0; k < 80; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          int a, b;
          a = $urandom_range(0, ND - 1);
          b = (a + $urandom_range(1, ND - 1)) % ND;
          bus.anodes   = ~((ND'(1) << a) | (ND'(1) << b));
          bus.segments = 7'($urandom);
          cyc($urandom_range(1, 5));
          m_err_m = 1'b1;
        end else begin
          int d, len, sel;
          logic [6:0] pat;
          logic [5:0] r;
          d   = $urandom_range(0, ND - 1);
          sel = $urandom_range(0, 13);
          pat = (sel < 10) ? glyph[sel] : (sel < 12) ? 7'h00 : 7'($urandom);
          len = $urandom_range(2, 7);
          dwell(d, pat, len);
          if (len >= SC) begin
            r = ref_dec(pat);
            m_val[d]   = r[5:2];
            m_blank[d] = r[1];
            if (r[0]) m_err_c = 1'b1;
            m_seen[d] = 1'b1;
            if (m_seen == '1) begin
              for (int i = 0; i < ND; i++) pk[4*i +: 4] = m_val[i];
              exp_q.push_back({pk, m_blank});
              m_seen = '0;
            end
          end
        end
        idle($urandom_range(1, 3));
      end
      idle(4);
      chk("rand_frame_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("rand_frame%0d", i), obs_q[i], exp_q[i]);
      chk("rand_err_code", bus.err_code, m_err_c);
      chk("rand_err_multi", bus.err_multi, m_err_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
